// File: rtl/johnson_ring_counter_pkg.sv
// Shared encodings and width helpers for the Johnson / one-hot ring counter.
package johnson_ring_counter_pkg;

    typedef enum logic {
        MODE_RING    = 1'b0,
        MODE_JOHNSON = 1'b1
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Phase spans 0..2N-1 in Johnson mode, which also covers the ring range 0..N-1.
    function automatic int unsigned phase_width(input int unsigned n);
        return $clog2(2 * n);
    endfunction

endpackage

// File: rtl/johnson_ring_counter_dff_cell.sv
// Single-bit D flip-flop with asynchronous active-low reset; one per counter bit.
module dff_cell (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_o <= 1'b0;
        end else begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/johnson_ring_counter.sv
// N-bit shift counter running as a Johnson or one-hot ring counter, with load,
// direction control, illegal-state correction and a decoded phase index.
module johnson_ring_counter
    import johnson_ring_counter_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned PW = phase_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          mode,
    input  logic          dir,
    input  logic          load,
    input  logic [N-1:0]  load_val,
    output logic [N-1:0]  q,
    output logic [PW-1:0] phase,
    output logic          legal,
    output logic          wrap,
    output logic          err
);

    logic [N-1:0]  q_q;
    logic [N-1:0]  q_d;
    logic          wrap_q;
    logic          wrap_d;
    logic          err_q;
    logic          err_d;

    logic          j_legal;
    logic [PW-1:0] j_phase;
    logic          r_legal;
    logic [PW-1:0] r_phase;
    logic [N-1:0]  lo_ones;
    logic [N-1:0]  hi_ones;
    logic [N-1:0]  onehot;

    logic          fb;
    logic [N-1:0]  step;
    logic          step_at_zero;

    for (genvar i = 0; i < N; i++) begin : g_bit
        dff_cell u_cell (
            .clk_i  (clk),
            .rst_ni (rst),
            .d_i    (q_d[i]),
            .q_o    (q_q[i])
        );
    end

    // Johnson decode: k ones filled from the LSB end give phase k, k ones
    // filled from the MSB end give phase 2N-k.
    always_comb begin
        j_legal = 1'b0;
        j_phase = '0;
        lo_ones = '0;
        hi_ones = '0;
        for (int unsigned k = 0; k <= N; k++) begin
            if (q_q == lo_ones) begin
                j_legal = 1'b1;
                j_phase = PW'(k);
            end
            if (k >= 1 && k <= N - 1 && q_q == hi_ones) begin
                j_legal = 1'b1;
                j_phase = PW'(2 * N - k);
            end
            if (k < N) begin
                lo_ones[k]         = 1'b1;
                hi_ones[N - 1 - k] = 1'b1;
            end
        end
    end

    always_comb begin
        r_legal = 1'b0;
        r_phase = '0;
        onehot  = N'(1);
        for (int unsigned i = 0; i < N; i++) begin
            if (q_q == onehot) begin
                r_legal = 1'b1;
                r_phase = PW'(i);
            end
            onehot = onehot << 1;
        end
    end

    always_comb begin
        if (mode == MODE_JOHNSON) begin
            legal = j_legal;
            phase = j_phase;
        end else begin
            legal = r_legal;
            phase = r_phase;
        end
    end

    always_comb begin
        if (dir == DIR_UP) begin
            fb   = (mode == MODE_JOHNSON) ? ~q_q[N-1] : q_q[N-1];
            step = {q_q[N-2:0], fb};
        end else begin
            fb   = (mode == MODE_JOHNSON) ? ~q_q[0] : q_q[0];
            step = {fb, q_q[N-1:1]};
        end
    end

    // A legal state always steps to a legal state, so phase 0 of the stepped
    // value is just the mode's origin pattern.
    assign step_at_zero = (mode == MODE_JOHNSON) ? (step == '0) : (step == N'(1));

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        if (load) begin
            q_d = load_val;
        end else if (en) begin
            if (legal) begin
                q_d    = step;
                wrap_d = step_at_zero;
            end else begin
                q_d   = (mode == MODE_JOHNSON) ? '0 : N'(1);
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign q    = q_q;
    assign wrap = wrap_q;
    assign err  = err_q;

endmodule

// File: tb/tb_johnson_ring_counter.sv
// Directed vector bench for the 4-bit Johnson / ring counter.
module tb_johnson_ring_counter;

    localparam int unsigned N  = 4;
    localparam int unsigned PW = 3;

    logic          clk;
    logic          rst;
    logic          en;
    logic          mode;
    logic          dir;
    logic          load;
    logic [N-1:0]  load_val;
    logic [N-1:0]  q;
    logic [PW-1:0] phase;
    logic          legal;
    logic          wrap;
    logic          err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string         name;
        logic          en;
        logic          mode;
        logic          dir;
        logic          load;
        logic [N-1:0]  lv;
        logic [N-1:0]  eq;
        logic [PW-1:0] ep;
        logic          el;
        logic          ew;
        logic          ee;
    } vec_t;

    vec_t vecs[$];

    johnson_ring_counter #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .dir      (dir),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .phase    (phase),
        .legal    (legal),
        .wrap     (wrap),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void add(input string nm, input logic e, input logic m, input logic d,
                                input logic ld, input logic [N-1:0] lv, input logic [N-1:0] eq,
                                input logic [PW-1:0] ep, input logic el, input logic ew,
                                input logic ee);
        vec_t v;
        v.name = nm; v.en = e; v.mode = m; v.dir = d; v.load = ld; v.lv = lv;
        v.eq = eq; v.ep = ep; v.el = el; v.ew = ew; v.ee = ee;
        vecs.push_back(v);
    endfunction

    task automatic check_all(input string nm, input logic [N-1:0] eq, input logic [PW-1:0] ep,
                             input logic el, input logic ew, input logic ee);
        check({nm, ".q"}, 32'(q), 32'(eq));
        check({nm, ".phase"}, 32'(phase), 32'(ep));
        check({nm, ".legal"}, 32'(legal), 32'(el));
        check({nm, ".wrap"}, 32'(wrap), 32'(ew));
        check({nm, ".err"}, 32'(err), 32'(ee));
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; mode = 1'b1; dir = 1'b0; load = 1'b0; load_val = '0;

        //   name      en m  d  ld lv       q        ph      lg ew ee
        add("jup1",    1, 1, 0, 0, 4'b0000, 4'b0001, 3'd1, 1, 0, 0);
        add("jup2",    1, 1, 0, 0, 4'b0000, 4'b0011, 3'd2, 1, 0, 0);
        add("jup3",    1, 1, 0, 0, 4'b0000, 4'b0111, 3'd3, 1, 0, 0);
        add("jup4",    1, 1, 0, 0, 4'b0000, 4'b1111, 3'd4, 1, 0, 0);
        add("jup5",    1, 1, 0, 0, 4'b0000, 4'b1110, 3'd5, 1, 0, 0);
        add("jup6",    1, 1, 0, 0, 4'b0000, 4'b1100, 3'd6, 1, 0, 0);
        add("jup7",    1, 1, 0, 0, 4'b0000, 4'b1000, 3'd7, 1, 0, 0);
        add("jup8",    1, 1, 0, 0, 4'b0000, 4'b0000, 3'd0, 1, 1, 0);
        add("jdn1",    1, 1, 1, 0, 4'b0000, 4'b1000, 3'd7, 1, 0, 0);
        add("jdn2",    1, 1, 1, 0, 4'b0000, 4'b1100, 3'd6, 1, 0, 0);
        add("jdn3",    1, 1, 1, 0, 4'b0000, 4'b1110, 3'd5, 1, 0, 0);
        add("jdn4",    1, 1, 1, 0, 4'b0000, 4'b1111, 3'd4, 1, 0, 0);
        add("jdn5",    1, 1, 1, 0, 4'b0000, 4'b0111, 3'd3, 1, 0, 0);
        add("jdn6",    1, 1, 1, 0, 4'b0000, 4'b0011, 3'd2, 1, 0, 0);
        add("jdn7",    1, 1, 1, 0, 4'b0000, 4'b0001, 3'd1, 1, 0, 0);
        add("jdn8",    1, 1, 1, 0, 4'b0000, 4'b0000, 3'd0, 1, 1, 0);
        add("rfix",    1, 0, 0, 0, 4'b0000, 4'b0001, 3'd0, 1, 0, 1);
        add("rup1",    1, 0, 0, 0, 4'b0000, 4'b0010, 3'd1, 1, 0, 0);
        add("rup2",    1, 0, 0, 0, 4'b0000, 4'b0100, 3'd2, 1, 0, 0);
        add("rup3",    1, 0, 0, 0, 4'b0000, 4'b1000, 3'd3, 1, 0, 0);
        add("rup4",    1, 0, 0, 0, 4'b0000, 4'b0001, 3'd0, 1, 1, 0);
        add("ldbad",   0, 1, 0, 1, 4'b0101, 4'b0101, 3'd0, 0, 0, 0);
        add("jfix",    1, 1, 0, 0, 4'b0000, 4'b0000, 3'd0, 1, 0, 1);
        add("ldprio",  1, 1, 0, 1, 4'b0011, 4'b0011, 3'd2, 1, 0, 0);
        add("hold1",   0, 1, 0, 0, 4'b0000, 4'b0011, 3'd2, 1, 0, 0);
        add("hold2",   0, 1, 0, 0, 4'b0000, 4'b0011, 3'd2, 1, 0, 0);
        add("hold3",   0, 1, 0, 0, 4'b0000, 4'b0011, 3'd2, 1, 0, 0);
        add("mswfix",  1, 0, 0, 0, 4'b0000, 4'b0001, 3'd0, 1, 0, 1);
        add("rdn1",    1, 0, 1, 0, 4'b0000, 4'b1000, 3'd3, 1, 0, 0);
        add("rdn2",    1, 0, 1, 0, 4'b0000, 4'b0100, 3'd2, 1, 0, 0);
        add("rdn3",    1, 0, 1, 0, 4'b0000, 4'b0010, 3'd1, 1, 0, 0);
        add("rdn4",    1, 0, 1, 0, 4'b0000, 4'b0001, 3'd0, 1, 1, 0);

        #12;
        check_all("reset", 4'b0000, 3'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            en = vecs[i].en; mode = vecs[i].mode; dir = vecs[i].dir;
            load = vecs[i].load; load_val = vecs[i].lv;
            @(posedge clk);
            #1;
            check_all(vecs[i].name, vecs[i].eq, vecs[i].ep, vecs[i].el, vecs[i].ew, vecs[i].ee);
        end

        // Reset mid-count: clear q without waiting for a clock edge.
        @(negedge clk);
        en = 1'b0; load = 1'b1; load_val = 4'b0000; mode = 1'b1; dir = 1'b0;
        @(negedge clk);
        load = 1'b0; en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("arst.pre_q", 32'(q), 32'(4'b0111));
        #1;
        rst = 1'b0;
        #1;
        check_all("arst", 4'b0000, 3'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1; en = 1'b0;
        @(posedge clk);
        #1;
        check("arst.hold_q", 32'(q), 32'(4'b0000));

        // Reset clears a pending err pulse asynchronously.
        @(negedge clk);
        mode = 1'b0; en = 1'b1;
        @(posedge clk);
        #1;
        check("arst.err_pre", 32'(err), 32'(1'b1));
        #1;
        rst = 1'b0;
        #1;
        check("arst.err", 32'(err), 32'(1'b0));
        check("arst.err_q", 32'(q), 32'(4'b0000));
        @(negedge clk);
        rst = 1'b1; en = 1'b0;

        // Reset clears a pending wrap pulse asynchronously.
        @(negedge clk);
        mode = 1'b1; dir = 1'b0; load = 1'b1; load_val = 4'b1000;
        @(negedge clk);
        load = 1'b0; en = 1'b1;
        @(posedge clk);
        #1;
        check("arst.wrap_pre", 32'(wrap), 32'(1'b1));
        #1;
        rst = 1'b0;
        #1;
        check("arst.wrap", 32'(wrap), 32'(1'b0));
        @(negedge clk);
        rst = 1'b1; en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/johnson_ring_counter.md
Name: johnson_ring_counter

Overview:
Configurable N-bit shift counter that runs as a Johnson (twisted-ring) counter or a one-hot ring counter. It is the stage directly downstream of the single D flip-flop cell: it chains N such cells and adds feedback, direction control, parallel load and illegal-state self-correction. It also provides a decoded phase index for the sequencing and clock-division logic that sits after it.

Parameters:
N, 4, counter width in bits; legal range 2..16.
PW, $clog2(2*N), width of the phase output; derived, not overridden.

Ports:
clk  input  1  single clock, rising-edge.
rst  input  1  reset, asynchronous, active-low.
en  input  1  advance one step on this clock edge.
mode  input  1  0 = ring (one-hot), 1 = Johnson.
dir  input  1  0 = shift toward MSB, 1 = shift toward LSB.
load  input  1  parallel load request.
load_val  input  N  value loaded into q.
q  output  N  counter state, registered.
phase  output  PW  decoded position; combinational from q.
legal  output  1  1 when q is a legal state for the current mode; combinational.
wrap  output  1  one-cycle registered pulse when a step lands on phase 0.
err  output  1  one-cycle registered pulse when a step corrected an illegal state.

Behaviour:
- Reset: the design has one clock, and reset is asynchronous and active-low. While rst=0, q=0, wrap=0 and err=0 immediately, with no clock edge required. Reset may assert mid-count and always wins.
- Priority on each rising edge: load, then en, then hold.
- load=1: q<=load_val, with no legality check. wrap<=0 and err<=0.
- en=1, load=0, legal=1: q steps.
  - dir=0: q<={q[N-2:0],fb}. fb=~q[N-1] in Johnson mode, q[N-1] in ring mode.
  - dir=1: q<={fb,q[N-1:1]}. fb=~q[0] in Johnson mode, q[0] in ring mode.
  - err<=0. wrap<=1 if and only if the stepped value decodes to phase 0.
- en=1, load=0, legal=0: q does not shift; it is corrected instead.
  - Johnson mode: q<=0.
  - Ring mode: q<=1 (LSB set only).
  - err<=1, wrap<=0.
- en=0, load=0: q holds; wrap<=0 and err<=0.
- Johnson legality: q is either k ones in the LSBs (k=0..N) or k ones in the MSBs (k=1..N-1).
  - Ones in the LSBs: phase=k.
  - Ones in the MSBs: phase=2N-k.
  - All other patterns: legal=0, phase=0.
- Ring legality: q is exactly one-hot, and phase is the index of the set bit. All-zero and multi-hot patterns give legal=0, phase=0.
- mode or dir may change on any cycle. The new value applies at the next step, and legality is judged under the new mode. For example, a Johnson state 0011 is illegal in ring mode and gets corrected on the next enabled edge.
- Wrap-around: in Johnson mode, phase 2N-1 steps to 0 with dir=0, and phase 0 steps to 2N-1 with dir=1. Ring mode wraps the same way with modulus N.
- Latency: q, wrap and err are updated on the edge. phase and legal follow q combinationally in the same cycle.

Decomposition:
- Shared header: mode encodings (MODE_RING=0, MODE_JOHNSON=1), dir encodings (DIR_UP=0, DIR_DOWN=1), and the PW width function.
- One sub-module, dff_cell: a 1-bit D flip-flop with asynchronous active-low reset, instantiated N times for q. Next-state mux, legality check and phase decode live in the top level.

Test Plan:
- Async reset: count to q=0111, then pull rst low 2 ns after an edge → q=0000, wrap=0, err=0 before the next edge. Release rst → q holds 0000.
- Johnson up (N=4, mode=1, dir=0, en=1 from reset) → q=0001,0011,0111,1111,1110,1100,1000,0000 with phase=1..7,0. wrap=1 only in the cycle q returns to 0000.
- Johnson down (mode=1, dir=1 from 0000) → q=1000,1100,1110,1111,0111,0011,0001,0000 with phase=7,6,...,1,0. wrap=1 on return to 0000.
- Ring from reset (mode=0, en=1) → first edge gives q=0001 with err=1. Then 0010,0100,1000,0001 with phase=1,2,3,0 and wrap=1 on the 0001 step.
- Load an illegal value (mode=1, load=1, load_val=0101) → q=0101, legal=0, phase=0. The next en edge gives q=0000, err=1.
- Hold and priority: en=0 for 3 cycles gives q unchanged, wrap=0, err=0. load=1 with en=1 and load_val=0011 gives q=0011, phase=2, with no step applied.
